// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the multiply/divide FSM state encoding.
package rv32_pkg;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned datapath: radix-2 shift-add multiply or
// restoring divide, operating on the {acc, mq} register pair.
module muldiv_core #(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] mq,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] acc_next,
   output logic [XLEN-1:0] mq_next
);

   logic [XLEN-1:0] addend;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   always_comb begin
      addend   = mq[0] ? b : '0;
      sum      = {1'b0, acc} + {1'b0, addend};
      shifted  = {acc, mq[XLEN-1]};
      diff     = shifted - {1'b0, b};
      acc_next = acc;
      mq_next  = mq;
      if (is_div) begin
         // Partial remainder stays below the divisor, so XLEN bits always hold it.
         if (!diff[XLEN]) begin
            acc_next = diff[XLEN-1:0];
            mq_next  = {mq[XLEN-2:0], 1'b1};
         end else begin
            acc_next = shifted[XLEN-1:0];
            mq_next  = {mq[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_next = sum[XLEN:1];
         mq_next  = {sum[0], mq[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: magnitude datapath
// with sign capture on entry, sign fix-up on exit, and a fast path for div special cases.
module ex_muldiv_unit
   import rv32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      done_rd
);

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   mq_q, mq_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        done_rd_q, done_rd_d;

   logic              accept;
   logic              a_signed, b_signed, sa_in, sb_in;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_result;
   logic [XLEN-1:0]   core_acc, core_mq;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

   muldiv_core #(.XLEN(XLEN)) u_core (
      .is_div   (f3_q[2]),
      .acc      (acc_q),
      .mq       (mq_q),
      .b        (b_q),
      .acc_next (core_acc),
      .mq_next  (core_mq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         b_q       <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         result_q  <= '0;
         done_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         b_q       <= b_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         result_q  <= result_d;
         done_rd_q <= done_rd_d;
      end
   end

   always_comb begin
      accept      = start & ~flush & (state_q == ST_IDLE);
      a_signed    = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                    (funct3 == F3_DIV)  | (funct3 == F3_REM);
      b_signed    = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);
      sa_in       = a_signed & op_a[XLEN-1];
      sb_in       = b_signed & op_b[XLEN-1];
      abs_a       = sa_in ? -op_a : op_a;
      abs_b       = sb_in ? -op_b : op_b;
      div_zero    = funct3[2] & (op_b == '0);
      div_ovf     = ((funct3 == F3_DIV) | (funct3 == F3_REM)) &
                    (op_a == XMIN) & (op_b == '1);
      fast        = div_zero | div_ovf;
      if (div_zero) fast_result = funct3[1] ? op_a : '1;
      else          fast_result = funct3[1] ? '0 : XMIN;

      prod        = {acc_q, mq_q};
      prod_fix    = (sa_q ^ sb_q) ? -prod : prod;
      quo_fix     = (sa_q ^ sb_q) ? -mq_q : mq_q;
      rem_fix     = sa_q ? -acc_q : acc_q;
      if (f3_q[2])              fix_result = f3_q[1] ? rem_fix : quo_fix;
      else if (f3_q[1:0] == 2'b00) fix_result = prod_fix[XLEN-1:0];
      else                      fix_result = prod_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_CALC;
         ST_CALC: begin
            if (flush)                            state_d = ST_IDLE;
            else if (cnt_q == CNT_W'(XLEN - 1))   state_d = ST_FIX;
         end
         ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      b_d       = b_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      result_d  = result_q;
      done_rd_d = done_rd_q;
      if (accept) begin
         // Multiply and divide share the load: acc cleared, mq = |a|, b = |b|.
         cnt_d = '0;
         acc_d = '0;
         mq_d  = abs_a;
         b_d   = abs_b;
         f3_d  = funct3;
         rd_d  = rd_in;
         sa_d  = sa_in;
         sb_d  = sb_in;
         if (fast) begin
            result_d  = fast_result;
            done_rd_d = rd_in;
         end
      end else if (state_q == ST_CALC && !flush) begin
         cnt_d = cnt_q + CNT_W'(1);
         acc_d = core_acc;
         mq_d  = core_mq;
      end else if (state_q == ST_FIX && !flush) begin
         result_d  = fix_result;
         done_rd_d = rd_q;
      end
   end

   always_comb begin
      stall_req = rst_n & ((start & ~flush & (state_q == ST_IDLE)) |
                           (state_q == ST_CALC) | (state_q == ST_FIX));
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      result    = result_q;
      done_rd   = done_rd_q;
   end

endmodule
